alg_sample_sequencer: RTL and testbench
=======================================

// Module: alg_sample_sequencer
// PURPOSE
//  Feeds the R-peak algorithm core (alg_core) and collects its results. Decodes ECG samples from the UART RX
//  byte stream and buffers them in a small FIFO. Releases one sample per sample-rate tick on ce/data_valid.
//  Frames every new rr_period result into two bytes on a valid/ready TX stream toward the UART.
//  Sits between uart_bus and alg_core in top_rpd_basys_3.
// PARAMETERS
//  SAMPLE_W    11      ECG sample width (fixed by byte format; 7 LSBs in byte0, 4 MSBs in byte1)
//  FIFO_DEPTH  8       sample FIFO entries, power of 2, >=2
//  SAMPLE_DIV  100000  clk cycles per sample tick (1 kHz @ 100 MHz), >=2
//  RR_W        16      width of core_rr_period
//  PEAK_W      32      width of core_r_peak_sample_num
// PORTS
//  clk                    in   1           system clock
//  nrst                   in   1           async active-low reset
//  en                     in   1           run enable (1 = feed core)
//  rx_data                in   8           received byte
//  rx_valid               in   1           1-cycle strobe, rx_data valid
//  tx_data                out  8           result byte to UART TX
//  tx_valid               out  1           tx_data valid, held until tx_ready
//  tx_ready               in   1           UART TX accepts byte
//  core_ce                out  1           alg_core clock enable
//  core_ecg_value         out  SAMPLE_W    sample to alg_core
//  core_data_valid        out  1           1-cycle strobe, sample valid
//  core_rr_period         in   RR_W        alg_core RR period
//  core_r_peak_sample_num in   PEAK_W      alg_core peak index; any change = new result
//  fifo_level             out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  ovf                    out  1           sticky: sample dropped, FIFO full
//  frame_err              out  1           1-cycle pulse: RX byte violated framing
//  result_lost            out  1           sticky: result overwritten before it was sent
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, divider 0, RX FSM in LO, TX FSM in IDLE, prev_peak = 0.
//  RX framing:
//   - byte0 = {1'b0, s[6:0]}; byte1 = {1'b1, 3'b000, s[10:7]}.
//   - LO state: bit7=0 -> hold low 7 bits, go HI. bit7=1 -> discard, pulse frame_err, stay LO.
//   - HI state: bit7=1 and bits[6:4]==0 -> push {b1[3:0], lo} at next edge, go LO.
//   - HI state: bit7=1 and bits[6:4]!=0 -> discard pair, pulse frame_err, go LO.
//   - HI state: bit7=0 -> byte replaces held low byte, pulse frame_err, stay HI.
//   - RX decode and FIFO push run regardless of en.
//  FIFO:
//   - Push while full (and no pop that cycle) -> sample dropped, ovf set until reset.
//   - Push and pop in the same cycle while full -> both proceed, level unchanged, no ovf.
//   - fifo_level is the registered occupancy after the edge.
//  Tick and feed:
//   - en=1: divider counts 0..SAMPLE_DIV-1 and wraps; tick when divider==SAMPLE_DIV-1.
//   - Tick with FIFO non-empty: pop. Next cycle core_ecg_value = popped sample, core_data_valid=1 for 1 cycle.
//   - Tick with FIFO empty: no strobe (underrun); core_ecg_value holds its last value.
//   - core_ce = en, registered (1 cycle latency).
//   - en=0: divider cleared to 0, core_ce=0, core_data_valid=0, FIFO contents kept.
//  Result capture (en=1 only):
//   - core_r_peak_sample_num != prev_peak -> latch core_rr_period into pend, set pend_v, update prev_peak.
//   - en=0: prev_peak still tracks the input, so no result is queued on re-enable.
//   - pend_v already set and TX not yet loaded -> overwrite pend, set result_lost.
//  TX FSM:
//   - IDLE: when pend_v -> load tx_buf <= pend, clear pend_v, go SEND_LO.
//   - SEND_LO: tx_data = tx_buf[7:0], tx_valid=1; on tx_ready go SEND_HI.
//   - SEND_HI: tx_data = tx_buf[15:8], tx_valid=1; on tx_ready go IDLE.
//   - tx_data is stable while tx_valid && !tx_ready.
//   - A capture in the cycle the FSM loads from pend goes into pend for the next frame; it is not lost.
//  Reset mid-operation: async clear of everything, including a partly sent TX frame.
// CONFIGURATION
//  ALG_SEQ_STATS_EN defined:
//   - adds out ports sample_cnt[15:0] (wrapping count of core_data_valid strobes)
//     and underrun_cnt[7:0] (saturating count of empty ticks).
//   - both reset to 0.
//  ALG_SEQ_STATS_EN undefined: these ports and their counters do not exist; all other behaviour is identical.
// STRUCTURE
//  alg_seq_pkg holds:
//   - SAMPLE_W, RX marker constants (MARK_LO=1'b0, MARK_HI=1'b1)
//   - typedef enum {RX_LO, RX_HI} rx_state_t
//   - typedef enum {TX_IDLE, TX_SEND_LO, TX_SEND_HI} tx_state_t
//  Sub-module alg_seq_fifo: sync FIFO with push/pop/full/empty/level, parameterised by width and depth.
// TESTING
//  1. Bytes 0x55,0x85 with en=1, SAMPLE_DIV=4 -> sample 0x2D5 pushed; next tick gives core_ecg_value=0x2D5, core_data_valid=1 for 1 cycle.
//  2. 9 sample pairs with en=0, FIFO_DEPTH=8 -> fifo_level=8, ovf=1, first 8 values then fed in order after en=1.
//  3. Bytes 0x85 (in LO), then 0x12,0x34,0x81 -> frame_err pulses twice; only sample {0x1,0x34}=0x0B4 pushed.
//  4. Peak num 0->5 with rr_period=0x0321, tx_ready=1 -> tx bytes 0x21 then 0x03, then IDLE.
//  5. tx_ready=0 and two peak changes (0x0100, 0x0200) -> frame 0x0100 sent, then 0x0200; a third change before load -> result_lost=1.
//  6. nrst low while in SEND_HI with FIFO level 3 -> tx_valid=0, fifo_level=0, all flags 0 immediately.

Source files
------------

// File: rtl/alg_seq_pkg.sv
// Shared types and constants for the ECG sample sequencer (RX byte framing, TX result framing).
package alg_seq_pkg;

    localparam int   SAMPLE_W = 11;
    localparam logic MARK_LO  = 1'b0;
    localparam logic MARK_HI  = 1'b1;

    typedef enum logic {
        RX_LO,
        RX_HI
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND_LO,
        TX_SEND_HI
    } tx_state_t;

endpackage

// File: rtl/alg_seq_fifo.sv
// Synchronous FIFO with fall-through read data; a push into a full FIFO only lands if a pop frees a slot.
module alg_seq_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)
                level <= level + LVL_ONE;
            else if (do_pop && !do_push)
                level <= level - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alg_sample_sequencer.sv
// Decodes RX sample pairs into a FIFO, feeds alg_core one sample per tick, frames rr_period results for TX.
// Optional ALG_SEQ_STATS_EN adds sample_cnt / underrun_cnt statistics ports.
module alg_sample_sequencer
    import alg_seq_pkg::*;
#(
    parameter int SAMPLE_W   = alg_seq_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_DIV = 100000,
    parameter int RR_W       = 16,
    parameter int PEAK_W     = 32
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        en,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        core_ce,
    output logic [SAMPLE_W-1:0]         core_ecg_value,
    output logic                        core_data_valid,
    input  logic [RR_W-1:0]             core_rr_period,
    input  logic [PEAK_W-1:0]           core_r_peak_sample_num,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf,
    output logic                        frame_err,
    output logic                        result_lost
`ifdef ALG_SEQ_STATS_EN
    ,
    output logic [15:0]                 sample_cnt,
    output logic [7:0]                  underrun_cnt
`endif
);

    localparam int               DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    rx_state_t             rx_state;
    logic [6:0]            lo_hold;
    logic                  push_vld_p1;
    logic [SAMPLE_W-1:0]   push_data_p1;

    logic [SAMPLE_W-1:0]   fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic                  pop;

    logic [PEAK_W-1:0]     prev_peak;
    logic [RR_W-1:0]       pend;
    logic                  pend_v;
    logic [15:0]           pend_word;
    logic                  capture;
    logic                  load;
    tx_state_t             tx_state;
    logic [7:0]            tx_hi;

    // ---- stage p0 -> p1: RX byte framing, decoded sample registered for the FIFO push
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_state    <= RX_LO;
            push_vld_p1 <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            push_vld_p1 <= 1'b0;
            frame_err   <= 1'b0;
            if (rx_valid) begin
                case (rx_state)
                    RX_LO: begin
                        if (rx_data[7] == MARK_LO) rx_state  <= RX_HI;
                        else                       frame_err <= 1'b1;
                    end
                    RX_HI: begin
                        // A second low byte replaces the held one; the pair restarts from it.
                        if (rx_data[7] == MARK_LO) begin
                            frame_err <= 1'b1;
                        end else begin
                            rx_state <= RX_LO;
                            if (rx_data[6:4] == 3'b000) push_vld_p1 <= 1'b1;
                            else                        frame_err   <= 1'b1;
                        end
                    end
                    default: rx_state <= RX_LO;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_valid && rx_data[7] == MARK_LO)
            lo_hold <= rx_data[6:0];
        if (rx_valid && rx_state == RX_HI && rx_data[7] == MARK_HI)
            push_data_p1 <= SAMPLE_W'({rx_data[3:0], lo_hold});
    end

    alg_seq_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push_vld_p1),
        .pop   (pop),
        .wdata (push_data_p1),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign tick = en && (div_cnt == DIV_LAST);
    assign pop  = tick && !fifo_empty;

    // ---- stage p1 -> p2: sample-rate tick, pop and core feed
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt         <= '0;
            core_ce         <= 1'b0;
            core_data_valid <= 1'b0;
            core_ecg_value  <= '0;
            ovf             <= 1'b0;
        end else begin
            div_cnt         <= (en && !tick) ? div_cnt + DIV_ONE : '0;
            core_ce         <= en;
            core_data_valid <= pop;
            if (pop) core_ecg_value <= fifo_rdata;
            if (push_vld_p1 && fifo_full && !pop) ovf <= 1'b1;
        end
    end

    assign pend_word = 16'(pend);
    assign capture   = en && (core_r_peak_sample_num != prev_peak);
    assign load      = (tx_state == TX_IDLE) && pend_v;

    // ---- result capture and TX framing (low byte first)
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_peak   <= '0;
            pend_v      <= 1'b0;
            result_lost <= 1'b0;
            tx_state    <= TX_IDLE;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
        end else begin
            prev_peak <= core_r_peak_sample_num;
            // A capture coinciding with a load refills pend for the next frame.
            if (capture)   pend_v <= 1'b1;
            else if (load) pend_v <= 1'b0;
            if (capture && pend_v && !load) result_lost <= 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (pend_v) begin
                        tx_state <= TX_SEND_LO;
                        tx_valid <= 1'b1;
                        tx_data  <= pend_word[7:0];
                    end
                end
                TX_SEND_LO: begin
                    if (tx_ready) begin
                        tx_state <= TX_SEND_HI;
                        tx_data  <= tx_hi;
                    end
                end
                TX_SEND_HI: begin
                    if (tx_ready) begin
                        tx_state <= TX_IDLE;
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) pend  <= core_rr_period;
        if (load)    tx_hi <= pend_word[15:8];
    end

`ifdef ALG_SEQ_STATS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample_cnt   <= '0;
            underrun_cnt <= '0;
        end else begin
            if (pop)                 sample_cnt   <= sample_cnt + 16'd1;
            if (tick && fifo_empty)  underrun_cnt <= sat_inc8(underrun_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_alg_sample_sequencer.sv
// Self-checking bench for alg_sample_sequencer: transaction-level model compared every cycle, plus directed literals.
module tb_alg_sample_sequencer;

    localparam int DEPTH = 8;
    localparam int DIV   = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] core_rr_period = '0;
    logic [31:0] core_r_peak_sample_num = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        core_ce;
    logic [10:0] core_ecg_value;
    logic        core_data_valid;
    logic [3:0]  fifo_level;
    logic        ovf;
    logic        frame_err;
    logic        result_lost;
`ifdef ALG_SEQ_STATS_EN
    logic [15:0] sample_cnt;
    logic [7:0]  underrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alg_sample_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk                    (clk),
        .nrst                   (nrst),
        .en                     (en),
        .rx_data                (rx_data),
        .rx_valid               (rx_valid),
        .tx_data                (tx_data),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .core_ce                (core_ce),
        .core_ecg_value         (core_ecg_value),
        .core_data_valid        (core_data_valid),
        .core_rr_period         (core_rr_period),
        .core_r_peak_sample_num (core_r_peak_sample_num),
        .fifo_level             (fifo_level),
        .ovf                    (ovf),
        .frame_err              (frame_err),
        .result_lost            (result_lost)
`ifdef ALG_SEQ_STATS_EN
        ,
        .sample_cnt             (sample_cnt),
        .underrun_cnt           (underrun_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample queue, byte queue for the frame in flight, one pending result.
    logic [10:0] m_q[$];
    logic [7:0]  m_txq[$];
    int          m_div;
    logic        m_ce, m_dv, m_ovf, m_fe, m_lost;
    logic [10:0] m_val;
    logic        m_have_lo;
    logic [6:0]  m_lo;
    logic        m_sched_v;
    logic [10:0] m_sched;
    logic [15:0] m_pend;
    logic        m_pend_v;
    logic [31:0] m_prev;
    logic [15:0] m_cnt;
    int          m_under;

    logic        s_en, s_rxv, s_ready, s_txv;
    logic [7:0]  s_rxd, s_txd;
    logic [15:0] s_rr;
    logic [31:0] s_peak;

    logic [10:0] dv_log[$];
    logic [7:0]  tx_log[$];
    int          fe_cnt = 0;

    task automatic model_reset();
        m_q.delete();
        m_txq.delete();
        m_div = 0; m_ce = 0; m_dv = 0; m_ovf = 0; m_fe = 0; m_lost = 0;
        m_val = '0; m_have_lo = 0; m_lo = '0; m_sched_v = 0; m_sched = '0;
        m_pend = '0; m_pend_v = 0; m_prev = '0; m_cnt = '0; m_under = 0;
    endtask

    task automatic model_step();
        bit tick, pop, load, capture;
        tick = s_en && (m_div == DIV - 1);
        pop  = tick && (m_q.size() > 0);
        m_dv = pop;
        if (pop) begin
            m_val = m_q.pop_front();
            m_cnt = m_cnt + 16'd1;
        end
        if (tick && !pop && m_under < 255) m_under++;
        if (m_sched_v) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_sched);
            else                    m_ovf = 1;
        end
        m_div = s_en ? (m_div + 1) % DIV : 0;
        m_ce  = s_en;

        m_sched_v = 0;
        m_fe      = 0;
        if (s_rxv) begin
            if (!s_rxd[7]) begin
                if (m_have_lo) m_fe = 1;
                m_lo      = s_rxd[6:0];
                m_have_lo = 1;
            end else if (!m_have_lo) begin
                m_fe = 1;
            end else begin
                m_have_lo = 0;
                if (s_rxd[6:4] == 3'b000) begin
                    m_sched   = {s_rxd[3:0], m_lo};
                    m_sched_v = 1;
                end else begin
                    m_fe = 1;
                end
            end
        end

        capture = s_en && (s_peak != m_prev);
        load = 0;
        if (m_txq.size() > 0) begin
            if (s_ready) void'(m_txq.pop_front());
        end else begin
            load = m_pend_v;
        end
        if (capture && m_pend_v && !load) m_lost = 1;
        if (load) begin
            m_txq.push_back(m_pend[7:0]);
            m_txq.push_back(m_pend[15:8]);
            m_pend_v = 0;
        end
        if (capture) begin
            m_pend   = s_rr;
            m_pend_v = 1;
        end
        m_prev = s_peak;
    endtask

    always @(posedge clk) begin
        s_en = en; s_rxv = rx_valid; s_rxd = rx_data; s_ready = tx_ready;
        s_rr = core_rr_period; s_peak = core_r_peak_sample_num;
        s_txv = tx_valid; s_txd = tx_data;
        #1;
        if (!nrst) begin
            model_reset();
        end else begin
            if (s_txv && s_ready) tx_log.push_back(s_txd);
            model_step();
        end
        check("tx_valid", tx_valid, m_txq.size() > 0);
        if (m_txq.size() > 0) check("tx_data", tx_data, m_txq[0]);
        check("core_ce", core_ce, m_ce);
        check("core_data_valid", core_data_valid, m_dv);
        check("core_ecg_value", core_ecg_value, m_val);
        check("fifo_level", fifo_level, m_q.size());
        check("ovf", ovf, m_ovf);
        check("frame_err", frame_err, m_fe);
        check("result_lost", result_lost, m_lost);
`ifdef ALG_SEQ_STATS_EN
        check("sample_cnt", sample_cnt, m_cnt);
        check("underrun_cnt", underrun_cnt, m_under);
`endif
        if (core_data_valid) dv_log.push_back(core_ecg_value);
        if (frame_err) fe_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [10:0] s);
        send_byte({1'b0, s[6:0]});
        send_byte({4'b1000, s[10:7]});
    endtask

    task automatic new_result(input logic [31:0] peak, input logic [15:0] rr);
        core_r_peak_sample_num = peak;
        core_rr_period         = rr;
        @(negedge clk);
    endtask

    task automatic wait_dv(input int n, input int budget);
        for (int i = 0; i < budget && dv_log.size() < n; i++) @(negedge clk);
        check("dv_count", dv_log.size(), n);
    endtask

    logic [10:0] smp[9];
    logic [31:0] peak_r;

    initial begin
        idle(3);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_core_dv", core_data_valid, 0);
        check("rst_ecg_value", core_ecg_value, 0);
        nrst = 1'b1;

        // Single sample 0x2D5 fed on the next tick
        en = 1'b1;
        dv_log.delete();
        send_byte(8'h55);
        send_byte(8'h85);
        wait_dv(1, 40);
        if (dv_log.size() >= 1) check("t1_sample", dv_log[0], 11'h2D5);
        idle(10);
        check("t1_single_strobe", dv_log.size(), 1);

        // Nine samples while disabled: overflow, then first eight fed in order
        en = 1'b0;
        dv_log.delete();
        for (int i = 0; i < 9; i++) begin
            smp[i] = 11'($urandom_range(0, 2047));
            send_sample(smp[i]);
        end
        idle(3);
        check("t2_level_full", fifo_level, 8);
        check("t2_ovf", ovf, 1);
        en = 1'b1;
        wait_dv(8, 100);
        for (int i = 0; i < 8; i++)
            if (dv_log.size() > i) check("t2_order", dv_log[i], smp[i]);
        idle(10);
        check("t2_no_ninth", dv_log.size(), 8);

        // Framing errors: stray high byte, then a replaced low byte
        dv_log.delete();
        fe_cnt = 0;
        send_byte(8'h85);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h81);
        wait_dv(1, 40);
        check("t3_frame_errs", fe_cnt, 2);
        if (dv_log.size() >= 1) check("t3_sample", dv_log[0], 11'h0B4);

        // One result framed as 0x21, 0x03
        tx_log.delete();
        tx_ready = 1'b1;
        new_result(32'd5, 16'h0321);
        idle(10);
        check("t4_bytes", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            check("t4_lo", tx_log[0], 8'h21);
            check("t4_hi", tx_log[1], 8'h03);
        end
        check("t4_idle", tx_valid, 0);

        // Backpressure: two results queue cleanly, a third before load is lost
        tx_ready = 1'b0;
        tx_log.delete();
        new_result(32'd6, 16'h0100);
        idle(3);
        new_result(32'd7, 16'h0200);
        idle(3);
        check("t5_not_lost", result_lost, 0);
        check("t5_held_lo", tx_data, 8'h00);
        tx_ready = 1'b1;
        idle(12);
        check("t5_bytes", tx_log.size(), 4);
        if (tx_log.size() >= 4) begin
            check("t5_b1", tx_log[1], 8'h01);
            check("t5_b3", tx_log[3], 8'h02);
        end
        tx_ready = 1'b0;
        new_result(32'd8, 16'h0300);
        idle(3);
        new_result(32'd9, 16'h0400);
        new_result(32'd10, 16'h0500);
        idle(2);
        check("t5_lost", result_lost, 1);
        tx_ready = 1'b1;
        idle(12);

        // Async reset while sending the high byte with three samples buffered
        tx_ready = 1'b0;
        new_result(32'd11, 16'hABCD);
        en = 1'b0;
        idle(2);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_sample(11'(100 + i));
        idle(2);
        check("t6_level", fifo_level, 3);
        check("t6_hi_byte", tx_data, 8'hAB);
        #3 nrst = 1'b0;
        #1;
        check("t6_tx_valid", tx_valid, 0);
        check("t6_level0", fifo_level, 0);
        check("t6_ovf", ovf, 0);
        check("t6_lost", result_lost, 0);
        check("t6_ce", core_ce, 0);
        @(negedge clk);
        nrst = 1'b1;
        idle(2);

        // Randomized traffic against the model
        peak_r = core_r_peak_sample_num;
        for (int c = 0; c < 1200; c++) begin
            int r;
            @(negedge clk);
            if (c == 600) nrst = 1'b0;
            if (c == 603) nrst = 1'b1;
            en       = ($urandom_range(0, 15) != 0);
            tx_ready = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r < 4)       rx_data = {1'b0, 7'($urandom_range(0, 127))};
            else if (r < 8)  rx_data = {4'b1000, 4'($urandom_range(0, 15))};
            else             rx_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                peak_r = peak_r + 32'd1;
                core_r_peak_sample_num = peak_r;
                core_rr_period = 16'($urandom_range(0, 65535));
            end
        end
        rx_valid = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
